// File: rtl/keypad_pkg.sv
// Shared types, key code constants and decode helpers for the keypad debounce/decoder.
package keypad_pkg;

  typedef enum logic [1:0] {
    IDLE,
    DEBOUNCE,
    PRESSED,
    RELEASE
  } kp_state_t;

  localparam logic [3:0] KEY_A    = 4'hA;
  localparam logic [3:0] KEY_B    = 4'hB;
  localparam logic [3:0] KEY_C    = 4'hC;
  localparam logic [3:0] KEY_D    = 4'hD;
  localparam logic [3:0] KEY_STAR = 4'hE;
  localparam logic [3:0] KEY_HASH = 4'hF;

  typedef struct packed {
    logic       ok;
    logic [1:0] idx;
  } kp_idx_t;

  // ok only when exactly one bit of v is low; idx is that bit's position.
  function automatic kp_idx_t onehot_low_decode(input logic [3:0] v);
    kp_idx_t    res;
    logic [3:0] one;
    res = '0;
    one = 4'b0001;
    for (int unsigned i = 0; i < 4; i++) begin
      if (v == ~(one << i)) begin
        res.ok  = 1'b1;
        res.idx = 2'(i);
      end
    end
    return res;
  endfunction

  function automatic logic [3:0] key_map(input logic [1:0] row, input logic [1:0] col);
    logic [3:0] code;
    code = '0;
    case ({row, col})
      4'h0: code = 4'h1;
      4'h1: code = 4'h2;
      4'h2: code = 4'h3;
      4'h3: code = KEY_A;
      4'h4: code = 4'h4;
      4'h5: code = 4'h5;
      4'h6: code = 4'h6;
      4'h7: code = KEY_B;
      4'h8: code = 4'h7;
      4'h9: code = 4'h8;
      4'hA: code = 4'h9;
      4'hB: code = KEY_C;
      4'hC: code = KEY_STAR;
      4'hD: code = 4'h0;
      4'hE: code = KEY_HASH;
      4'hF: code = KEY_D;
      default: code = '0;
    endcase
    return code;
  endfunction

endpackage

// File: rtl/keypad_sync2.sv
// Two-flop synchronizer for the active-low row pads; idles at 1111 (no row pulled).
module keypad_sync2 (
  input  logic       clock_Value,
  input  logic       reset_n,
  input  logic [3:0] d,
  output logic [3:0] q
);

  logic [3:0] meta;

  always_ff @(posedge clock_Value or negedge reset_n) begin
    if (!reset_n) begin
      meta <= '1;
      q    <= '1;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/keypad_debounce_decoder.sv
// Keypad debounce and key-code decoder fed by a free-running one-hot-low column scanner.
// Optional auto-repeat strobes are enabled by defining KEYPAD_AUTOREPEAT_EN.
module keypad_debounce_decoder #(
  parameter int unsigned DEBOUNCE_SAMPLES = 16,
  parameter int unsigned RELEASE_SAMPLES  = 16,
  parameter int unsigned REPEAT_SAMPLES   = 256
) (
  input  logic       clock_Value,
  input  logic       reset_n,
  input  logic [3:0] rowValue,
  input  logic [3:0] column,
  output logic [3:0] keyCode,
  output logic       keyValid,
  output logic       keyHeld
);

  import keypad_pkg::*;

  localparam int unsigned CNT_MAX = (DEBOUNCE_SAMPLES > RELEASE_SAMPLES) ? DEBOUNCE_SAMPLES
                                                                          : RELEASE_SAMPLES;
  localparam int unsigned CW      = $clog2(CNT_MAX + 1);

  logic [3:0]    row_s;
  logic [3:0]    col_d1, col_d2;
  kp_idx_t       cdec, rdec;
  kp_state_t     state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d, cnt_inc;
  logic [1:0]    lat_row_q, lat_row_d, lat_col_q, lat_col_d;
  logic [3:0]    code_q;
  logic          valid_q;
  logic          accept, strobe;
  logic          pressed, considered, row_up;

  keypad_sync2 u_sync (
    .clock_Value (clock_Value),
    .reset_n     (reset_n),
    .d           (rowValue),
    .q           (row_s)
  );

  // Column delayed to match the synchronizer so each row sample pairs with its own column.
  assign cdec       = onehot_low_decode(col_d2);
  assign rdec       = onehot_low_decode(row_s);
  assign pressed    = cdec.ok && rdec.ok;
  assign considered = cdec.ok && (cdec.idx == lat_col_q);
  assign row_up     = row_s[lat_row_q];
  assign cnt_inc    = (cnt_q == CW'(CNT_MAX)) ? cnt_q : cnt_q + 1'b1;

`ifdef KEYPAD_AUTOREPEAT_EN
  localparam int unsigned RW = $clog2(REPEAT_SAMPLES + 1);
  logic [RW-1:0] rpt_q, rpt_d, rpt_inc;
  logic          rpt_fire;

  assign rpt_inc = (rpt_q == RW'(REPEAT_SAMPLES)) ? rpt_q : rpt_q + 1'b1;

  always_ff @(posedge clock_Value or negedge reset_n) begin
    if (!reset_n) rpt_q <= '0;
    else          rpt_q <= rpt_d;
  end
`else
  logic unused_repeat;
  assign unused_repeat = (REPEAT_SAMPLES != 0);
`endif

  always_ff @(posedge clock_Value or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      lat_row_q <= '0;
      lat_col_q <= '0;
      code_q    <= '0;
      valid_q   <= 1'b0;
      col_d1    <= '1;
      col_d2    <= '1;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      lat_row_q <= lat_row_d;
      lat_col_q <= lat_col_d;
      valid_q   <= strobe;
      col_d1    <= column;
      col_d2    <= col_d1;
      if (accept) code_q <= key_map(lat_row_q, lat_col_q);
    end
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    lat_row_d = lat_row_q;
    lat_col_d = lat_col_q;
    accept    = 1'b0;
`ifdef KEYPAD_AUTOREPEAT_EN
    // Repeat count survives only while staying in PRESSED; every other path clears it.
    rpt_d     = '0;
    rpt_fire  = 1'b0;
`endif
    case (state_q)
      IDLE: begin
        if (pressed) begin
          lat_col_d = cdec.idx;
          lat_row_d = rdec.idx;
          cnt_d     = CW'(1);
          state_d   = DEBOUNCE;
        end
      end
      DEBOUNCE: begin
        if (considered) begin
          if (pressed && (rdec.idx == lat_row_q)) begin
            cnt_d = cnt_inc;
            if (cnt_inc >= CW'(DEBOUNCE_SAMPLES)) begin
              state_d = PRESSED;
              cnt_d   = '0;
              accept  = 1'b1;
            end
          end else begin
            state_d = IDLE;
            cnt_d   = '0;
          end
        end
      end
      PRESSED: begin
`ifdef KEYPAD_AUTOREPEAT_EN
        rpt_d = rpt_q;
`endif
        if (considered) begin
          if (row_up) begin
`ifdef KEYPAD_AUTOREPEAT_EN
            rpt_d = '0;
`endif
            if (RELEASE_SAMPLES <= 1) begin
              state_d = IDLE;
              cnt_d   = '0;
            end else begin
              state_d = RELEASE;
              cnt_d   = CW'(1);
            end
          end else begin
`ifdef KEYPAD_AUTOREPEAT_EN
            rpt_d = rpt_inc;
            if (rpt_inc >= RW'(REPEAT_SAMPLES)) begin
              rpt_d    = '0;
              rpt_fire = 1'b1;
            end
`endif
          end
        end
      end
      RELEASE: begin
        if (considered) begin
          if (row_up) begin
            cnt_d = cnt_inc;
            if (cnt_inc >= CW'(RELEASE_SAMPLES)) begin
              state_d = IDLE;
              cnt_d   = '0;
            end
          end else begin
            state_d = PRESSED;
            cnt_d   = '0;
          end
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase
`ifdef KEYPAD_AUTOREPEAT_EN
    strobe = accept | rpt_fire;
`else
    strobe = accept;
`endif
  end

  always_comb begin
    keyCode  = code_q;
    keyValid = valid_q;
    keyHeld  = (state_q == PRESSED) || (state_q == RELEASE);
  end

endmodule

// File: tb/tb_keypad_debounce_decoder.sv
// Directed bench for keypad_debounce_decoder with a scanner/keypad model and strobe scoreboard.
module tb_keypad_debounce_decoder;

  localparam int unsigned DEB = 4;
  localparam int unsigned REL = 4;
  localparam int unsigned RPT = 8;

  logic        clock_Value = 1'b0;
  logic        reset_n;
  logic [3:0]  rowValue;
  logic [3:0]  column;
  logic [3:0]  keyCode;
  logic        keyValid;
  logic        keyHeld;
  logic [15:0] keys = '0;
  int unsigned ptr;
  int          checks = 0;
  int          passes = 0;
  logic [3:0]  exp_q[$];

  keypad_debounce_decoder #(
    .DEBOUNCE_SAMPLES (DEB),
    .RELEASE_SAMPLES  (REL),
    .REPEAT_SAMPLES   (RPT)
  ) dut (
    .clock_Value (clock_Value),
    .reset_n     (reset_n),
    .rowValue    (rowValue),
    .column      (column),
    .keyCode     (keyCode),
    .keyValid    (keyValid),
    .keyHeld     (keyHeld)
  );

  initial forever #5 clock_Value = ~clock_Value;

  function automatic logic [3:0] rows_for(input logic [3:0] col, input logic [15:0] k);
    logic [3:0] r;
    r = 4'b1111;
    for (int ri = 0; ri < 4; ri++)
      for (int ci = 0; ci < 4; ci++)
        if (!col[ci] && k[ri*4+ci]) r[ri] = 1'b0;
    return r;
  endfunction

  function automatic logic [3:0] col_drive(input int unsigned c);
    logic [3:0] one;
    one = 4'b0001;
    return ~(one << c);
  endfunction

  // Free-running scanner; the keypad matrix pulls a row low while its column is driven.
  initial begin
    ptr      = 0;
    column   = col_drive(0);
    rowValue = 4'b1111;
    forever begin
      @(posedge clock_Value);
      #1;
      ptr      = (ptr + 1) % 4;
      column   = col_drive(ptr);
      rowValue = rows_for(column, keys);
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
  endtask

  task automatic cycles(input int n);
    repeat (n) @(negedge clock_Value);
  endtask

  // Change the key matrix on the negedge just before column col is next driven.
  task automatic set_keys_aligned(input logic [15:0] k, input int unsigned col);
    logic [3:0] prev;
    logic       found;
    prev  = col_drive((col + 3) % 4);
    found = 1'b0;
    for (int i = 0; i < 8 && !found; i++) begin
      @(negedge clock_Value);
      if (column == prev) found = 1'b1;
    end
    check("scan_align", {31'd0, found}, 32'd1);
    keys = k;
  endtask

  // Sample n of an aligned press is acted on at edge 4n; acceptance lands on edge 16.
  task automatic check_accept(input string name);
    cycles(15);
    check({name, "_before_accept"}, {31'd0, keyHeld}, 32'd0);
    cycles(1);
    check({name, "_at_accept"}, {31'd0, keyHeld}, 32'd1);
  endtask

  initial begin : monitor
    logic [3:0] e;
    logic       prev_valid;
    prev_valid = 1'b0;
    forever begin
      @(negedge clock_Value);
      if (keyValid) begin
        check("strobe_single_cycle", {31'd0, prev_valid}, 32'd0);
        checks++;
        if (exp_q.size() == 0) begin
          $display("FAIL unexpected_strobe: keyCode=%0h, no strobe expected", keyCode);
        end else begin
          e = exp_q.pop_front();
          if (keyCode === e) passes++;
          else $display("FAIL key_code: got %0h, expected %0h", keyCode, e);
        end
      end
      prev_valid = keyValid;
    end
  end

  initial begin
    reset_n = 1'b0;
    cycles(4);
    #1;
    check("reset_keyCode", {28'd0, keyCode}, 32'h0);
    check("reset_keyValid", {31'd0, keyValid}, 32'd0);
    check("reset_keyHeld", {31'd0, keyHeld}, 32'd0);
    cycles(1);
    reset_n = 1'b1;
    cycles(8);

    // Key 5: row1/col1, held 40 cycles.
    exp_q.push_back(4'h5);
    set_keys_aligned(16'h0001 << 5, 1);
    check_accept("key5");
    cycles(24);
    keys = '0;
    cycles(8);
    check("key5_held_during_release", {31'd0, keyHeld}, 32'd1);
    cycles(24);
    check("key5_released", {31'd0, keyHeld}, 32'd0);

    // Key #: row3/col2 bounces on alternate aligned samples, then stays pressed.
    set_keys_aligned(16'h0001 << 14, 2);
    cycles(4); keys = '0;
    cycles(4); keys = 16'h0001 << 14;
    cycles(4); keys = '0;
    cycles(4);
    check("hash_no_accept_in_bounce", {31'd0, keyHeld}, 32'd0);
    exp_q.push_back(4'hF);
    keys = 16'h0001 << 14;
    check_accept("hash");
    cycles(8);
    keys = '0;
    cycles(32);
    check("hash_released", {31'd0, keyHeld}, 32'd0);

    // Ghosting: rows 0 and 2 on col0 together never qualify.
    set_keys_aligned((16'h0001 << 0) | (16'h0001 << 8), 0);
    cycles(32);
    check("ghost_no_press", {31'd0, keyHeld}, 32'd0);
    keys = '0;
    cycles(16);
    exp_q.push_back(4'h1);
    set_keys_aligned(16'h0001 << 0, 0);
    check_accept("key1_after_ghost");
    keys = '0;
    cycles(32);

    // Key 9: release glitch after two released samples returns to PRESSED silently.
    exp_q.push_back(4'h9);
    set_keys_aligned(16'h0001 << 10, 2);
    cycles(24);
    keys = '0;
    cycles(8);
    check("key9_held_in_release", {31'd0, keyHeld}, 32'd1);
    keys = 16'h0001 << 10;
    cycles(12);
    check("key9_held_after_glitch", {31'd0, keyHeld}, 32'd1);
    keys = '0;
    cycles(32);
    check("key9_released", {31'd0, keyHeld}, 32'd0);

    // Reset while debouncing key 1 at count 3.
    set_keys_aligned(16'h0001 << 0, 0);
    cycles(13);
    reset_n = 1'b0;
    #1;
    check("midreset_keyCode", {28'd0, keyCode}, 32'h0);
    check("midreset_keyValid", {31'd0, keyValid}, 32'd0);
    check("midreset_keyHeld", {31'd0, keyHeld}, 32'd0);
    cycles(3);
    exp_q.push_back(4'h1);
    reset_n = 1'b1;
    cycles(12);
    check("postreset_needs_full_count", {31'd0, keyHeld}, 32'd0);
    cycles(10);
    check("postreset_accepted", {31'd0, keyHeld}, 32'd1);
    keys = '0;
    cycles(32);

`ifdef KEYPAD_AUTOREPEAT_EN
    // Key 0 held for 22 samples: strobes at acceptance and after 8 and 16 more samples.
    exp_q.push_back(4'h0);
    exp_q.push_back(4'h0);
    exp_q.push_back(4'h0);
    set_keys_aligned(16'h0001 << 13, 1);
    cycles(88);
    keys = '0;
    cycles(40);
    check("key0_released", {31'd0, keyHeld}, 32'd0);
`endif

    cycles(10);
    check("all_strobes_seen", exp_q.size(), 32'd0);
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
